// File: rtl/fifo_share_arb_if.sv
// fifo_share_arb_if: requester, FIFO-side and drain-control signals of fifo_share_arb
// slave modport: the arbiter side; master modport: requesters and the attached FIFO.
interface fifo_share_arb_if #(
  parameter int DW = 4,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH + 1);
  logic req_a, req_b;
  logic [DW-1:0] din_a, din_b;
  logic gnt_a, gnt_b;
  logic [DW-1:0] fifo_din;
  logic fifo_wr_en, fifo_rd_en;
  logic fifo_full, fifo_empty;
  logic drain_start, drain_busy, drain_done;
  logic rd_valid;
  logic [LW-1:0] level;
  logic err;
  modport slave (
    input  req_a, req_b, din_a, din_b, fifo_full, fifo_empty, drain_start,
    output gnt_a, gnt_b, fifo_din, fifo_wr_en, fifo_rd_en, drain_busy, drain_done, rd_valid, level, err
  );
  modport master (
    output req_a, req_b, din_a, din_b, fifo_full, fifo_empty, drain_start,
    input  gnt_a, gnt_b, fifo_din, fifo_wr_en, fifo_rd_en, drain_busy, drain_done, rd_valid, level, err
  );
endinterface

// File: rtl/fifo_share_arb.sv
// fifo_share_arb: round-robin sharing of one native FIFO write port by two requesters plus a burst drainer
// Ports: CLK; RST_N (async, active-low); bus (fifo_share_arb_if.slave):
//   req_a/req_b, din_a/din_b in, gnt_a/gnt_b out  - requester handshakes
//   fifo_din, fifo_wr_en, fifo_rd_en out; fifo_full, fifo_empty in - native FIFO port
//   drain_start in; drain_busy, drain_done, rd_valid out - read burst control
//   level out (internal occupancy), err out (sticky protocol error)
// Define FIFO_ERR_CHECK_EN to build the full/empty misuse checker; otherwise err is constant 0.
module fifo_share_arb #(
  parameter int DW = 4,
  parameter int DEPTH = 16,
  parameter int BURST = 2
) (
  input logic CLK,
  input logic RST_N,
  fifo_share_arb_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] fifo_din_q, fifo_din_d;
  logic gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic wr_q, wr_d, rd_q, rd_d, rd_valid_q, rd_valid_d;
  logic busy_q, busy_d, done_q, done_d, last_b_q, last_b_d;
  logic elig_a, elig_b;

  // A requester granted last cycle sits out one cycle, so each side gets at most one word per two cycles.
  always_comb begin
    elig_a = bus.req_a && !gnt_a_q && level_q < LW'(DEPTH);
    elig_b = bus.req_b && !gnt_b_q && level_q < LW'(DEPTH);
    gnt_a_d = elig_a && (!elig_b || last_b_q);
    gnt_b_d = elig_b && !gnt_a_d;
    wr_d = gnt_a_d || gnt_b_d;
    fifo_din_d = gnt_a_d ? bus.din_a : gnt_b_d ? bus.din_b : '0;
    last_b_d = wr_d ? gnt_b_d : last_b_q;
  end

  // The drain ends when the burst is used up or when the words present before this cycle's
  // write are exhausted, so a requester refilling during the drain does not extend it.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.drain_start) state_d = DRAIN;
      end
      DRAIN: begin
        rd_d = level_q != '0 && cnt_q < CW'(BURST);
        cnt_d = cnt_q + CW'(rd_d);
        if (cnt_d == CW'(BURST) || level_q == LW'(rd_d)) state_d = DONE;
      end
      default: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = state_d != IDLE;
    rd_valid_d = rd_q;
    level_d = level_q + LW'(wr_d) - LW'(rd_d);
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q <= '0;
      level_q <= '0;
      fifo_din_q <= '0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      fifo_din_q <= fifo_din_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      rd_valid_q <= rd_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      last_b_q <= last_b_d;
    end

`ifdef FIFO_ERR_CHECK_EN
  logic err_q, err_d;
  // The FIFO acts on the edge after an enable is presented, so the flags are judged at that edge.
  always_comb err_d = err_q || (wr_q && bus.fifo_full) || (rd_q && bus.fifo_empty);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) err_q <= 1'b0;
    else err_q <= err_d;
  assign bus.err = err_q;
`else
  logic unused_flags;
  assign unused_flags = bus.fifo_full ^ bus.fifo_empty;
  assign bus.err = 1'b0;
`endif

  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.fifo_din = fifo_din_q;
  assign bus.fifo_wr_en = wr_q;
  assign bus.fifo_rd_en = rd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.drain_busy = busy_q;
  assign bus.drain_done = done_q;
  assign bus.level = level_q;
endmodule

// File: doc/fifo_share_arb.md
FIFO_SHARE_ARB -- requirements
Module: fifo_share_arb

Interface
REQ-001 SHALL have parameter DW, default 4, the FIFO data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, the attached native FIFO depth in words.
REQ-003 SHALL have parameter BURST, default 2, the maximum number of reads per drain command.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_a / req_b  input  1  write request from requester A / B.
REQ-007 SHALL have ports din_a / din_b  input  DW  write data from A / B, valid while the matching req is high.
REQ-008 SHALL have ports gnt_a / gnt_b  output  1  one-cycle pulse: the word from A / B has been issued to the FIFO.
REQ-009 SHALL have port fifo_din  output  DW  FIFO write data.
REQ-010 SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-011 SHALL have port fifo_rd_en  output  1  FIFO read enable.
REQ-012 SHALL have ports fifo_full / fifo_empty  input  1  FIFO status flags.
REQ-013 SHALL have port drain_start  input  1  pulse requesting one read burst.
REQ-014 SHALL have port drain_busy  output  1  high while a drain is in progress.
REQ-015 SHALL have port drain_done  output  1  one-cycle pulse at the end of a drain.
REQ-016 SHALL have port rd_valid  output  1  fifo_dout is valid this cycle (fifo_rd_en delayed by one cycle).
REQ-017 SHALL have port level  output  clog2(DEPTH+1)  internal occupancy count.
REQ-018 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-019 SHALL register all outputs; a grant, fifo_wr_en and fifo_din all appear together on the edge after the request is sampled.
REQ-020 SHALL mark a requester eligible when its req=1, its gnt is currently 0, and level < DEPTH; at most one word per requester every 2 cycles.
REQ-021 SHALL grant the single eligible requester when only one is eligible; when both are eligible it SHALL grant the one not granted last (round-robin).
REQ-022 SHALL, on a grant, set fifo_wr_en=1 and fifo_din=din of the winner for exactly one cycle; otherwise fifo_wr_en=0 and fifo_din=0.
REQ-023 SHALL implement the drain FSM IDLE -> DRAIN on drain_start=1; drain_start is ignored outside IDLE.
REQ-024 SHALL, in DRAIN, assert fifo_rd_en for one cycle per cycle while level > 0 and the number of reads issued < BURST.
REQ-025 SHALL move DRAIN -> DONE once BURST reads are issued, or on a cycle with level = 0, and SHALL move DONE -> IDLE after 1 cycle with drain_done=1.
REQ-026 SHALL hold drain_busy=1 in DRAIN and DONE.
REQ-027 SHALL update level +1 on each wr_en issue and -1 on each rd_en issue, with no change when both occur in the same cycle.
REQ-028 SHALL never wrap level: it never exceeds DEPTH and never goes below 0.
REQ-029 SHALL allow writes and reads concurrently; full blocks only writes and empty blocks only reads.

Reset
REQ-030 SHALL, while RST_N=0, asynchronously clear all outputs to 0, level to 0, the FSM to IDLE, the burst counter to 0 and the round-robin pointer to "B last" so that A wins first.
REQ-031 SHALL, on reset asserted mid-drain, abort the drain with no drain_done pulse; the external FIFO contents are outside this block's reset.

Configuration
REQ-032 SHALL, with macro FIFO_ERR_CHECK_EN defined, set err=1 and hold it until reset when fifo_wr_en=1 while fifo_full=1 or fifo_rd_en=1 while fifo_empty=1, sampled at the edge the FIFO acts.
REQ-033 SHALL, without FIFO_ERR_CHECK_EN, tie err to constant 0 and include no checking logic.

Verification
REQ-034 SHALL cover: req_a=1 din_a=9, req_b=0 -> next cycle gnt_a=1, fifo_wr_en=1, fifo_din=9, level=1.
REQ-035 SHALL cover: after reset, req_a and req_b held high with din_a=9 and din_b=14 -> grants alternate A,B,A,B and fifo_din alternates 9,14; one write per cycle.
REQ-036 SHALL cover: level=16 with both requests high -> no grant and fifo_wr_en=0 until a read issues, then exactly one grant.
REQ-037 SHALL cover: level=5, drain_start pulse -> fifo_rd_en high for 2 cycles, rd_valid 1 cycle later, drain_done 1 cycle after the last read, level=3.
REQ-038 SHALL cover: level=1, drain_start -> 1 read, then DONE; a simultaneous write during that read leaves level at 1.
REQ-039 SHALL cover: with FIFO_ERR_CHECK_EN defined, force fifo_full=1 while a write is issued -> err=1 and stays 1 until RST_N=0.
